// File: rtl/cisr_pkg.sv
// Shared types and sizing helpers for the result transmitter.
package cisr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } tx_state_t;

  localparam int BYTES_PER_WORD    = 4;
  localparam int WORDS_PER_CHANNEL = 2;

  function automatic int bytes_per_set(input int num_channels);
    return num_channels * WORDS_PER_CHANNEL * BYTES_PER_WORD;
  endfunction

endpackage

// File: rtl/result_set_fifo.sv
// Power-of-two FIFO of whole result sets. The read port is registered and looks
// one entry ahead on a pop, so the head is ready the cycle after the pop.
module result_set_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      count_reg, count_next;
  logic             do_push, do_pop;

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rd_data = rd_data_reg;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_push) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (do_pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage carries no reset so it can map onto block RAM; emptiness is
  // defined purely by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
    rd_data_reg <= mem[rd_ptr_next];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: rtl/result_transmitter.sv
// Buffers parallel result sets and serialises each one, little-endian per word,
// as a byte stream with valid/ready handshake to the host endpoint.
module result_transmitter
  import cisr_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CHANNELS-1:0][31:0] in_values,
  input  logic [NUM_CHANNELS-1:0][31:0] in_row_ids,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [7:0]                    tx_byte,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          tx_last,
  output logic [15:0]                   sets_sent,
  output logic                          busy
);

  localparam int BPS   = bytes_per_set(NUM_CHANNELS);
  localparam int WIDTH = NUM_CHANNELS * 64;
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

  tx_state_t         state_reg, state_next;
  logic [WIDTH-1:0]  holding_reg, holding_next;
  logic [1:0]        byte_reg, byte_next;
  logic              word_reg, word_next;
  logic [CH_W-1:0]   channel_reg, channel_next;
  logic [15:0]       sets_sent_reg, sets_sent_next;
  logic              ready_en_reg;

  logic [WIDTH-1:0]  fifo_wr_data, fifo_rd_data;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;

  logic [7:0]        set_bytes [BPS];
  logic [CH_W+2:0]   byte_sel;
  logic              last_byte;

  // Each channel occupies 64 bits: value in the low word, row id above it,
  // so byte k of the set is simply byte k of the packed vector.
  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_pack
      assign fifo_wr_data[gi*64 +: 32]      = in_values[gi];
      assign fifo_wr_data[gi*64 + 32 +: 32] = in_row_ids[gi];
    end
    for (genvar gi = 0; gi < BPS; gi++) begin : g_bytes
      assign set_bytes[gi] = holding_reg[gi*8 +: 8];
    end
  endgenerate

  // in_ready stays low through reset and rises on the first edge after it.
  assign in_ready  = ready_en_reg && !fifo_full;
  assign fifo_push = in_valid && in_ready;

  result_set_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (fifo_wr_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign byte_sel  = {channel_reg, word_reg, byte_reg};
  assign last_byte = (channel_reg == LAST_CH) && word_reg && (byte_reg == 2'd3);

  assign tx_valid  = (state_reg == SEND);
  assign tx_last   = tx_valid && last_byte;
  assign tx_byte   = tx_valid ? set_bytes[byte_sel] : 8'h00;
  assign sets_sent = sets_sent_reg;
  assign busy      = (state_reg != IDLE) || !fifo_empty;

  always_comb begin
    state_next     = state_reg;
    holding_next   = holding_reg;
    byte_next      = byte_reg;
    word_next      = word_reg;
    channel_next   = channel_reg;
    sets_sent_next = sets_sent_reg;
    fifo_pop       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) state_next = LOAD;
      end
      LOAD: begin
        holding_next = fifo_rd_data;
        byte_next    = 2'd0;
        word_next    = 1'b0;
        channel_next = '0;
        state_next   = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          if (last_byte) begin
            fifo_pop       = 1'b1;
            sets_sent_next = sets_sent_reg + 16'd1;
            state_next     = (fifo_count > CW'(1)) ? LOAD : IDLE;
          end else if (byte_reg == 2'd3) begin
            byte_next = 2'd0;
            if (word_reg) begin
              word_next    = 1'b0;
              channel_next = channel_reg + 1'b1;
            end else begin
              word_next = 1'b1;
            end
          end else begin
            byte_next = byte_reg + 2'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      holding_reg   <= '0;
      byte_reg      <= 2'd0;
      word_reg      <= 1'b0;
      channel_reg   <= '0;
      sets_sent_reg <= 16'd0;
      ready_en_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      holding_reg   <= holding_next;
      byte_reg      <= byte_next;
      word_reg      <= word_next;
      channel_reg   <= channel_next;
      sets_sent_reg <= sets_sent_next;
      ready_en_reg  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_result_transmitter.sv
// Directed bench for result_transmitter: byte order, backpressure, FIFO limits,
// same-cycle push/pop, mid-set reset and sets_sent wrap.
module tb_result_transmitter;

  localparam int NCH = 4;
  localparam int BPS = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0][31:0] in_values;
  logic [NCH-1:0][31:0] in_row_ids;
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           tx_byte;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_last;
  logic [15:0]          sets_sent;
  logic                 busy;

  always #5 clk = ~clk;

  result_transmitter #(.NUM_CHANNELS(NCH), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_values  (in_values),
    .in_row_ids (in_row_ids),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_last    (tx_last),
    .sets_sent  (sets_sent),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] val_base;
    logic [31:0] row_base;
  } set_vec_t;

  typedef struct {
    int         idx;
    logic [7:0] b;
  } byte_vec_t;

  set_vec_t   sets  [16];
  byte_vec_t  ref37 [12];
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input int k, input int i);
    logic [31:0] word;
    int c, w, b;
    c = i / 8;
    w = (i / 4) % 2;
    b = i % 4;
    word = (w == 1) ? (sets[k].row_base + 32'(c)) : (sets[k].val_base + 32'(c));
    return word[b*8 +: 8];
  endfunction

  task automatic load_set(input int k);
    for (int c = 0; c < NCH; c++) begin
      in_values[c]  = sets[k].val_base + 32'(c);
      in_row_ids[c] = sets[k].row_base + 32'(c);
    end
    for (int i = 0; i < BPS; i++) exp_q.push_back(model_byte(k, i));
  endtask

  // Called at a negedge; returns at a negedge after the set was accepted.
  task automatic send_set(input int k);
    int cyc;
    load_set(k);
    in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) check("send_timeout", 32'(cyc), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    $display("[TB] sent set %0d", k);
  endtask

  task automatic recv_bytes(input int n, input int pct, output int cycles);
    int got, cyc;
    bit stalled, r;
    logic [7:0] held;
    logic held_last;
    got = 0; cyc = 0; stalled = 0; held = 8'h00; held_last = 1'b0;
    while (got < n && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        check("stall_hold", {22'd0, tx_valid, tx_last, tx_byte}, {22'd0, 1'b1, held_last, held});
        stalled = 0;
      end
      r = ($urandom_range(99) < pct);
      tx_ready = r;
      if (tx_valid) begin
        if (r) begin
          rx_q.push_back(tx_byte);
          check("tx_last", {31'd0, tx_last}, {31'd0, ((got % BPS) == BPS - 1)});
          got++;
        end else begin
          stalled = 1;
          held = tx_byte;
          held_last = tx_last;
        end
      end
    end
    if (got < n) check("recv_timeout", 32'(got), 32'(n));
    cycles = cyc;
    @(negedge clk);
    tx_ready = 1'b0;
    $display("[TB] received %0d bytes in %0d cycles", got, cyc);
  endtask

  task automatic compare_stream(input string name);
    int bad, first;
    bad = 0; first = -1;
    check({name, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      if (rx_q[i] !== exp_q[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    check({name, "_bad_bytes"}, 32'(bad), 32'd0);
    if (bad != 0) $display("[TB] first bad byte at %0d", first);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    for (int k = 0; k < 16; k++) begin
      sets[k].val_base = 32'h1122_3344 + 32'(k) * 32'h0101_0100;
      sets[k].row_base = 32'(k) * 32'h10;
    end
    sets[0] = '{32'h1122_3344, 32'h0};
    ref37[0]  = '{0,  8'h44}; ref37[1]  = '{1,  8'h33}; ref37[2]  = '{2,  8'h22};
    ref37[3]  = '{3,  8'h11}; ref37[4]  = '{4,  8'h00}; ref37[5]  = '{8,  8'h45};
    ref37[6]  = '{11, 8'h11}; ref37[7]  = '{12, 8'h01}; ref37[8]  = '{16, 8'h46};
    ref37[9]  = '{20, 8'h02}; ref37[10] = '{24, 8'h47}; ref37[11] = '{28, 8'h03};

    rst = 1'b1; in_valid = 1'b0; tx_ready = 1'b0;
    in_values = '0; in_row_ids = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_last",  {31'd0, tx_last}, 32'd0);
    check("rst_tx_byte",  {24'd0, tx_byte}, 32'd0);
    check("rst_busy",     {31'd0, busy}, 32'd0);
    check("rst_sets_sent", {16'd0, sets_sent}, 32'd0);
    rst = 1'b0;
    #1 check("ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("ready_after_edge", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Single set: latency, byte order, tx_last, count
    load_set(0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_e0_valid", {31'd0, tx_valid}, 32'd0);
    check("lat_e0_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("lat_e1_valid", {31'd0, tx_valid}, 32'd0);
    @(negedge clk);
    check("lat_e2_valid", {31'd0, tx_valid}, 32'd1);
    recv_bytes(32, 100, cyc);
    check("single_cycles", 32'(cyc), 32'd32);
    for (int v = 0; v < 12; v++)
      check($sformatf("ref_byte_%0d", ref37[v].idx), {24'd0, rx_q[ref37[v].idx]}, {24'd0, ref37[v].b});
    compare_stream("single");
    check("single_sets_sent", {16'd0, sets_sent}, 32'd1);
    check("single_idle_busy", {31'd0, busy}, 32'd0);

    // Fill the FIFO under backpressure, then drain at full rate
    for (int k = 1; k <= 4; k++) send_set(k);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    load_set(5);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("fifth_stalled", {31'd0, in_ready}, 32'd0);
    fork
      begin
        int w;
        w = 0;
        while (!in_ready && w < 2000) begin
          @(negedge clk);
          w++;
        end
        if (w >= 2000) check("fifth_accept_timeout", 32'(w), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
      end
      recv_bytes(160, 100, cyc);
    join
    check("burst_cycles", 32'(cyc), 32'd164);
    compare_stream("burst");
    check("burst_sets_sent", {16'd0, sets_sent}, 32'd6);

    // Random backpressure
    send_set(6);
    send_set(7);
    recv_bytes(64, 50, cyc);
    compare_stream("random_ready");
    check("random_sets_sent", {16'd0, sets_sent}, 32'd8);

    // Push and pop on the same edge with two sets buffered
    send_set(8);
    send_set(9);
    recv_bytes(31, 100, cyc);
    check("pre_pop_last", {31'd0, tx_last}, 32'd1);
    load_set(10);
    in_valid = 1'b1;
    tx_ready = 1'b1;
    rx_q.push_back(tx_byte);
    @(negedge clk);
    in_valid = 1'b0;
    tx_ready = 1'b0;
    check("same_edge_ready", {31'd0, in_ready}, 32'd1);
    send_set(11);
    check("count3_ready", {31'd0, in_ready}, 32'd1);
    send_set(12);
    check("count4_full", {31'd0, in_ready}, 32'd0);
    recv_bytes(128, 100, cyc);
    repeat (4) @(negedge clk);
    check("same_edge_drained_valid", {31'd0, tx_valid}, 32'd0);
    check("same_edge_drained_busy", {31'd0, busy}, 32'd0);
    compare_stream("same_edge");
    check("same_edge_sets_sent", {16'd0, sets_sent}, 32'd13);

    // Reset in the middle of a set
    send_set(13);
    recv_bytes(9, 100, cyc);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("midrst_tx_byte", {24'd0, tx_byte}, 32'd0);
    check("midrst_tx_last", {31'd0, tx_last}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_sets_sent", {16'd0, sets_sent}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    exp_q.delete();
    @(negedge clk);
    check("postrst_no_resume", {30'd0, tx_valid, busy}, 32'd0);
    send_set(14);
    recv_bytes(32, 100, cyc);
    compare_stream("post_reset");
    check("postrst_sets_sent", {16'd0, sets_sent}, 32'd1);

    // sets_sent wrap
    force dut.sets_sent_reg = 16'hFFFF;
    @(posedge clk);
    #1 release dut.sets_sent_reg;
    check("preload_sets_sent", {16'd0, sets_sent}, 32'h0000_FFFF);
    @(negedge clk);
    send_set(15);
    recv_bytes(32, 100, cyc);
    compare_stream("wrap");
    check("wrap_sets_sent", {16'd0, sets_sent}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/result_transmitter.md
RESULT_TRANSMITTER -- requirements
Module: result_transmitter

Interface
REQ-001 The block SHALL have parameter NUM_CHANNELS, default 4, meaning parallel result lanes per set.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning result sets buffered; a power of two, at least 2.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port in_values, input, [NUM_CHANNELS-1:0][31:0], per-channel result value.
REQ-006 The block SHALL have port in_row_ids, input, [NUM_CHANNELS-1:0][31:0], per-channel row index.
REQ-007 The block SHALL have port in_valid, input, 1, result set offered.
REQ-008 The block SHALL have port in_ready, output, 1, result set accepted when in_valid is also high.
REQ-009 The block SHALL have port tx_byte, output, 8, byte sent to the host block endpoint.
REQ-010 The block SHALL have port tx_valid, output, 1, tx_byte is valid.
REQ-011 The block SHALL have port tx_ready, input, 1, endpoint consumes the byte when tx_valid is also high.
REQ-012 The block SHALL have port tx_last, output, 1, high on the final byte of a set.
REQ-013 The block SHALL have port sets_sent, output, 16, count of completed sets; wraps at 2^16.
REQ-014 The block SHALL have port busy, output, 1, high when the FSM is not IDLE or the FIFO is not empty.

Function
REQ-015 The FIFO SHALL write one set on each edge where in_valid and in_ready are both high.
REQ-016 in_ready SHALL equal NOT full, with no bypass: a full FIFO refuses writes even in a pop cycle.
REQ-017 The byte order of a set SHALL be, per channel from 0 upward: value bytes [7:0], [15:8], [23:16], [31:24], then row_id bytes in the same order.
REQ-018 Each set SHALL be NUM_CHANNELS*8 bytes (32 at default).
REQ-019 The FSM SHALL have states IDLE, LOAD and SEND.
REQ-020 In IDLE, a non-empty FIFO SHALL move the FSM to LOAD.
REQ-021 In LOAD, the FSM SHALL copy the FIFO head into a holding register, clear the byte, word and channel counters, and go to SEND.
REQ-022 In SEND, tx_valid SHALL be 1, and each tx_valid-and-tx_ready edge SHALL advance to the next byte.
REQ-023 On the handshake of the final byte, the FSM SHALL pop the FIFO, increment sets_sent, and go to LOAD if FIFO count exceeds 1, otherwise to IDLE.
REQ-024 While tx_valid is high and tx_ready is low, tx_byte, tx_last and tx_valid SHALL hold stable.
REQ-025 tx_valid SHALL be 0 in IDLE and LOAD.
REQ-026 Latency: for a set accepted on edge E0 into an empty, idle block, tx_valid SHALL rise after edge E0+2.
REQ-027 tx_last SHALL equal (channel == NUM_CHANNELS-1) AND word == row_id AND byte index == 3.
REQ-028 A set written in the same cycle as a pop SHALL be counted correctly, with the count unchanged.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 tx_ready held high SHALL sustain one byte per cycle within a set, with a 1-cycle LOAD bubble between sets.

Reset
REQ-031 Asserting rst at any time SHALL asynchronously force the FSM to IDLE, empty the FIFO, and zero all counters and the holding register.
REQ-032 While rst is asserted, in_ready, tx_valid, tx_last, busy, tx_byte and sets_sent SHALL all be 0.
REQ-033 Reset mid-set SHALL abort the set, and no partial set SHALL resume.
REQ-034 in_ready SHALL rise on the first edge after rst deasserts.

Structure
REQ-035 Package cisr_pkg SHALL hold the tx_state_t typedef (IDLE, LOAD, SEND), BYTES_PER_WORD=4, and a function computing bytes per set from NUM_CHANNELS.
REQ-036 The FIFO SHALL be a sub-module result_set_fifo (parameters WIDTH, DEPTH; signals push, pop, full, empty, count), instantiated with width NUM_CHANNELS*64.

Verification
REQ-037 One set, value[c]=0x11223344+c, row_id[c]=c, tx_ready=1 -> bytes 44 33 22 11 00 00 00 00 45 33 22 11 01 00 00 00 …; 32 bytes; tx_last only on byte 32; sets_sent=1.
REQ-038 Five back-to-back sets with tx_ready=0 -> in_ready falls after the 4th write, 5th set stalls; then tx_ready=1 -> all 160 bytes in order and the 5th set accepted after the first pop.
REQ-039 tx_ready toggled pseudo-randomly at 50% -> tx_byte stable under stall and the byte stream identical to the tx_ready=1 run.
REQ-040 Write and pop in the same cycle with the FIFO at count 2 -> count stays 2 and no set is lost or duplicated.
REQ-041 rst pulsed during byte 10 of a set -> outputs 0 immediately, FIFO empty, then a fresh set sends from byte 0.
REQ-042 Preload sets_sent to 0xFFFF by sending 65535 sets (or force), send one more -> sets_sent = 0x0000.
